seg7_scan_ctrl: RTL

- Drives the 4-digit 7-segment display. It sits directly downstream of the memory-dump display path and consumes the 16-bit data word that path reads back.
- Owns its own digit-rate prescaler off the system clock, so no separate 1 kHz divided clock is needed.
- Double-buffers the displayed word so a frame never mixes digits from two different words.
- Provides leading-zero blanking, decimal points and a one-cycle anti-ghost guard between digits.

---
 rtl/seg7_scan_ctrl.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - 4-digit multiplexed 7-segment scan controller
//
// Purpose:
//   Scans a 16-bit hex word onto a 4-digit common-anode 7-segment display.
//   An internal prescaler sets the digit slot length, the shown word is
//   double-buffered so a frame never mixes two words, leading zeros can be
//   blanked, each digit has its own decimal point, and one dark guard cycle
//   separates adjacent digits to suppress ghosting.
//
// Optional feature macro: SEG_BLINK_EN (adds the blink input and blink timer).
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous active-high reset
//   value[15:0]  in   word to show; [15:12] is digit 3 (leftmost)
//   value_valid  in   one-cycle strobe capturing value
//   blank_lz     in   1 = blank leading zero digits (digit 0 never blanked)
//   dp[3:0]      in   decimal point per digit, 1 = lit
//   blink        in   (SEG_BLINK_EN only) 1 = blink the display
//   sel[3:0]     out  digit enables, active-low one-hot
//   leds[6:0]    out  segments {g,f,e,d,c,b,a}, active-low
//   dp_n         out  decimal point segment, active-low
//   frame_done   out  one-cycle pulse when digit 3's slot ends

module seg7_scan_ctrl #(
    parameter int TICK_DIV     = 100000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic        value_valid,
    input  logic        blank_lz,
    input  logic [3:0]  dp,
`ifdef SEG_BLINK_EN
    input  logic        blink,
`endif
    output logic [3:0]  sel,
    output logic [6:0]  leds,
    output logic        dp_n,
    output logic        frame_done
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   disp_q, disp_d;
    logic [15:0]   pend_q, pend_d;
    logic          pend_flag_q, pend_flag_d;
    logic [3:0]    sel_q, sel_d;
    logic [6:0]    leds_q, leds_d;
    logic          dp_n_q, dp_n_d;
    logic          frame_done_q, frame_done_d;

    logic          tick;
    logic          frame_bnd;
    logic [3:0]    nib;
    logic          lead_zero;
    logic          dark;

    function automatic logic [6:0] hex_decode(input logic [3:0] n);
        case (n)
            4'h0:    hex_decode = 7'b1000000;
            4'h1:    hex_decode = 7'b1111001;
            4'h2:    hex_decode = 7'b0100100;
            4'h3:    hex_decode = 7'b0110000;
            4'h4:    hex_decode = 7'b0011001;
            4'h5:    hex_decode = 7'b0010010;
            4'h6:    hex_decode = 7'b0000010;
            4'h7:    hex_decode = 7'b1111000;
            4'h8:    hex_decode = 7'b0000000;
            4'h9:    hex_decode = 7'b0010000;
            4'hA:    hex_decode = 7'b0001000;
            4'hB:    hex_decode = 7'b0000011;
            4'hC:    hex_decode = 7'b1000110;
            4'hD:    hex_decode = 7'b0100001;
            4'hE:    hex_decode = 7'b0000110;
            default: hex_decode = 7'b0001110;
        endcase
    endfunction

    assign tick      = (cnt_q == CNT_LAST);
    assign frame_bnd = tick && (idx_q == 2'd3);
    assign nib       = disp_q[{idx_q, 2'b00} +: 4];

    // A digit is a leading zero when it and every digit to its left are zero.
    always_comb begin
        lead_zero = 1'b0;
        case (idx_q)
            2'd3:    lead_zero = (disp_q[15:12] == 4'h0);
            2'd2:    lead_zero = (disp_q[15:8]  == 8'h00);
            2'd1:    lead_zero = (disp_q[15:4]  == 12'h000);
            default: lead_zero = 1'b0;
        endcase
    end

`ifdef SEG_BLINK_EN
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          phase_q, phase_d;

    always_comb begin
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        if (!blink) begin
            bcnt_d  = '0;
            phase_d = 1'b0;
        end else if (frame_bnd) begin
            if (bcnt_q == BLINK_LAST) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bcnt_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
        end
    end

    // Gate on the live blink input so dropping it restores the next cycle.
    assign dark = blink & phase_q;
`else
    assign dark = 1'b0;
`endif

    // Scan position and word buffering.
    always_comb begin
        cnt_d       = tick ? '0 : cnt_q + 1'b1;
        idx_d       = tick ? idx_q + 2'd1 : idx_q;
        disp_d      = disp_q;
        pend_d      = pend_q;
        pend_flag_d = pend_flag_q;
        if (frame_bnd) begin
            // A strobe landing on the boundary bypasses the pending buffer.
            if (value_valid) begin
                disp_d      = value;
                pend_flag_d = 1'b0;
            end else if (pend_flag_q) begin
                disp_d      = pend_q;
                pend_flag_d = 1'b0;
            end
        end else if (value_valid) begin
            pend_d      = value;
            pend_flag_d = 1'b1;
        end
    end

    // Registered outputs: the edge that consumes a tick loads the guard
    // state, every other edge loads the digit selected by the current index.
    always_comb begin
        sel_d        = 4'hF;
        leds_d       = 7'h7F;
        dp_n_d       = 1'b1;
        frame_done_d = frame_bnd;
        if (!tick) begin
            sel_d  = ~(4'b0001 << idx_q);
            leds_d = (blank_lz && lead_zero) ? 7'h7F : hex_decode(nib);
            dp_n_d = ~dp[idx_q];
            if (dark) begin
                leds_d = 7'h7F;
                dp_n_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            disp_q       <= 16'h0000;
            pend_q       <= 16'h0000;
            pend_flag_q  <= 1'b0;
            sel_q        <= 4'hF;
            leds_q       <= 7'h7F;
            dp_n_q       <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_flag_q  <= pend_flag_d;
            sel_q        <= sel_d;
            leds_q       <= leds_d;
            dp_n_q       <= dp_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign sel        = sel_q;
    assign leds       = leds_q;
    assign dp_n       = dp_n_q;
    assign frame_done = frame_done_q;

endmodule
